vga_fb_arbiter: RTL and testbench



---
 rtl/vga_fb_pkg.sv | 7 +
 rtl/vga_fb_write_fifo.sv | 42 ++++
 rtl/vga_fb_arbiter.sv | 90 +++++++++
 tb/tb_vga_fb_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared constants and frame-phase type for the VGA framebuffer arbiter
package vga_fb_pkg;
    localparam int ADDR_W = 16;
    localparam int IMG_W  = 2 << 8;
    localparam int IMG_H  = 2 * 240;
    typedef enum logic [0:0] {ACTIVE, VBLANK} phase_e;
endpackage

// File: rtl/vga_fb_write_fifo.sv
// vga_fb_write_fifo: synchronous FIFO with registered full/empty flags
module vga_fb_write_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 24
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_q, rd_q;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  empty_q, full_q;
    assign cnt_d   = cnt_q + (DEPTH_LOG2+1)'(i_push) - (DEPTH_LOG2+1)'(i_pop);
    assign o_data  = mem_q[rd_q];
    assign o_empty = empty_q;
    assign o_full  = full_q;
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (i_push) begin
                mem_q[wr_q] <= i_data;
                wr_q        <= wr_q + DEPTH_LOG2'(1);
            end
            if (i_pop) rd_q <= rd_q + DEPTH_LOG2'(1);
            cnt_q   <= cnt_d;
            empty_q <= cnt_d == '0;
            full_q  <= cnt_d == (DEPTH_LOG2+1)'(DEPTH);
        end
    end
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer between 2x-scaled VGA scanout
// and a FIFO-buffered pixel writer; scanout owns even window columns.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int                    BIT_DEPTH       = 11,
    parameter int                    X_OFFSET        = 64,
    parameter int                    FB_WIDTH_LOG2   = 8,
    parameter int                    FB_HEIGHT       = 240,
    parameter int                    DATA_WIDTH      = 8,
    parameter int                    FIFO_DEPTH_LOG2 = 2,
    parameter logic [DATA_WIDTH-1:0] BORDER_COLOUR   = 8'h0F
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [BIT_DEPTH-1:0]  i_x,
    input  logic [BIT_DEPTH-1:0]  i_y,
    input  logic                  i_visible,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic [DATA_WIDTH-1:0] o_pixel,
    output logic                  o_pixel_valid,
    output logic                  o_vblank_start
);
    localparam int WIN_W = 2 << FB_WIDTH_LOG2;
    localparam int WIN_H = 2 * FB_HEIGHT;
    localparam int ENT_W = ADDR_W + DATA_WIDTH;
    logic [BIT_DEPTH-1:0]  xo;
    logic                  in_win, scan, push, pop, fifo_empty, fifo_full;
    logic [ENT_W-1:0]      head;
    logic                  win1_q, scan1_q, valid_q, vbs_q, vbs_d;
    logic [DATA_WIDTH-1:0] pixel_q, pixel_d;
    phase_e                phase_q, phase_d;
    assign xo     = i_x - BIT_DEPTH'(X_OFFSET);
    assign in_win = i_visible && i_x >= BIT_DEPTH'(X_OFFSET) && xo < BIT_DEPTH'(WIN_W)
                 && i_y < BIT_DEPTH'(WIN_H);
    assign scan   = in_win && !xo[0];
    assign push   = i_wr_valid && o_wr_ready;
    assign pop    = !scan && !fifo_empty;
    assign o_wr_ready  = !fifo_full;
    assign o_mem_we    = pop;
    assign o_mem_addr  = scan ? {i_y[FB_WIDTH_LOG2:1], xo[FB_WIDTH_LOG2:1]} : head[ENT_W-1 -: ADDR_W];
    assign o_mem_wdata = head[DATA_WIDTH-1:0];
    assign o_pixel        = pixel_q;
    assign o_pixel_valid  = valid_q;
    assign o_vblank_start = vbs_q;
    vga_fb_write_fifo #(
        .DEPTH_LOG2(FIFO_DEPTH_LOG2),
        .WIDTH     (ENT_W)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_push   (push),
        .i_data   ({i_wr_addr, i_wr_data}),
        .i_pop    (pop),
        .o_data   (head),
        .o_empty  (fifo_empty),
        .o_full   (fifo_full)
    );
    // odd window columns repeat the pixel fetched on the preceding even column
    always_comb begin
        pixel_d = !win1_q ? BORDER_COLOUR : scan1_q ? i_mem_rdata : pixel_q;
        phase_d = (phase_q == ACTIVE && i_x == '0 && i_y == BIT_DEPTH'(WIN_H)) ? VBLANK
                : (phase_q == VBLANK && i_x == '0 && i_y == '0) ? ACTIVE : phase_q;
        vbs_d   = phase_q == ACTIVE && phase_d == VBLANK;
    end
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            win1_q  <= 1'b0;
            scan1_q <= 1'b0;
            valid_q <= 1'b0;
            pixel_q <= BORDER_COLOUR;
            phase_q <= ACTIVE;
            vbs_q   <= 1'b0;
        end else begin
            win1_q  <= in_win;
            scan1_q <= scan;
            valid_q <= win1_q;
            pixel_q <= pixel_d;
            phase_q <= phase_d;
            vbs_q   <= vbs_d;
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: randomized and directed checks of vga_fb_arbiter against a queue-based model
module tb_vga_fb_arbiter;
    import vga_fb_pkg::*;
    localparam int XO = 64;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] x, y;
    logic        vis, wr_valid, wr_ready, mem_we, pixel_valid, vbs;
    logic [15:0] wr_addr, mem_addr;
    logic [7:0]  wr_data, mem_wdata, mem_rdata, pixel;
    logic [7:0]  ram [0:65535];
    int          checks = 0, errors = 0;
    typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_x(x), .i_y(y), .i_visible(vis),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_pixel(pixel), .o_pixel_valid(pixel_valid), .o_vblank_start(vbs)
    );

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    function automatic bit win(input int xx, input int yy, input bit v);
        return v && xx >= XO && xx < XO + IMG_W && yy < IMG_H;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; wr_valid = 1; wr_addr = 16'h0055; wr_data = 8'h77; vis = 0; x = 700; y = 10;
        repeat (3) cyc();
        #2;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_hold_we got %b exp 0", mem_we); end
        checks++; if (pixel !== 8'h0F) begin errors++; $display("FAIL rst_hold_pixel got %h exp 0f", pixel); end
        cyc();
        rst_n = 1; wr_valid = 0;
        #2;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", wr_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", mem_we); end
        checks++; if (pixel !== 8'h0F) begin errors++; $display("FAIL rst_pixel got %h exp 0f", pixel); end
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL rst_pvalid got %b exp 0", pixel_valid); end
        checks++; if (vbs !== 1'b0) begin errors++; $display("FAIL rst_vbs got %b exp 0", vbs); end
        for (int i = 0; i < 3; i++) begin
            cyc(); #2;
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_leak_we got %b exp 0", mem_we); end
        end
        cyc();
    endtask

    task automatic test_scanout();
        logic [15:0] ea;
        logic [7:0]  ep;
        bit          ev;
        vis = 1; y = 2;
        for (int xx = 60; xx < 74; xx++) begin
            x = 11'(xx);
            #2;
            if (win(xx, 2, 1) && (xx - XO) % 2 == 0) begin
                ea = 16'((2 / 2) * 256 + (xx - XO) / 2);
                checks++; if (mem_we !== 1'b0 || mem_addr !== ea) begin errors++;
                    $display("FAIL scan_read x=%0d got we=%b addr=%h exp we=0 addr=%h", xx, mem_we, mem_addr, ea); end
            end
            if (xx >= 62) begin
                ev = win(xx - 2, 2, 1);
                ep = ev ? 8'((xx - 2 - XO) / 2) : 8'h0F;
                checks++; if (pixel !== ep || pixel_valid !== ev) begin errors++;
                    $display("FAIL scan_pixel x=%0d got %h/%b exp %h/%b", xx, pixel, pixel_valid, ep, ev); end
            end
            cyc();
        end
        vis = 0; x = 700;
        cyc();
    endtask

    task automatic test_write_burst();
        wr_t        q[$];
        logic [7:0] dat [6];
        int         sent = 0;
        bit         rdy, slot, ewe, stalled = 0;
        foreach (dat[i]) dat[i] = 8'($urandom);
        vis = 1; y = 10; x = 100;
        for (int c = 0; c < 40 && (sent < 6 || q.size() > 0); c++) begin
            wr_valid = sent < 6; wr_addr = 16'h1234 + 16'(sent); wr_data = dat[sent < 6 ? sent : 0];
            #2;
            rdy  = q.size() < 4;
            slot = win(int'(x), int'(y), vis) && (int'(x) - XO) % 2 == 0;
            ewe  = !slot && q.size() > 0;
            checks++; if (wr_ready !== rdy) begin errors++; $display("FAIL burst_ready c=%0d got %b exp %b", c, wr_ready, rdy); end
            checks++; if (mem_we !== ewe) begin errors++; $display("FAIL burst_we c=%0d got %b exp %b", c, mem_we, ewe); end
            if (ewe) begin
                checks++; if (mem_addr !== q[0].a || mem_wdata !== q[0].d) begin errors++;
                    $display("FAIL burst_data got %h:%h exp %h:%h", mem_addr, mem_wdata, q[0].a, q[0].d); end
            end
            if (mem_we === 1'b1) begin
                checks++; if ((int'(x) - XO) % 2 != 1) begin errors++; $display("FAIL burst_parity x=%0d got even exp odd", x); end
            end
            if (!rdy) stalled = 1;
            if (ewe) void'(q.pop_front());
            if (wr_valid && rdy) begin q.push_back('{wr_addr, wr_data}); sent++; end
            cyc();
            if (c >= 4) x++;
        end
        wr_valid = 0;
        checks++; if (sent != 6 || q.size() != 0) begin errors++; $display("FAIL burst_timeout got sent=%0d left=%0d exp 6/0", sent, q.size()); end
        checks++; if (!stalled) begin errors++; $display("FAIL burst_stall got none exp ready low"); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (ram[16'h1234 + i] !== dat[i]) begin errors++;
                $display("FAIL burst_ram i=%0d got %h exp %h", i, ram[16'h1234 + i], dat[i]); end
        end
        vis = 0; x = 700;
        cyc();
    endtask

    task automatic test_hblank_write();
        logic [7:0] d = 8'($urandom);
        vis = 0; x = 700; y = 10; wr_valid = 1; wr_addr = 16'h00AA; wr_data = d;
        #2;
        checks++; if (wr_ready !== 1'b1 || mem_we !== 1'b0) begin errors++;
            $display("FAIL hb_handshake got ready=%b we=%b exp 1/0", wr_ready, mem_we); end
        cyc();
        wr_valid = 0;
        #2;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h00AA || mem_wdata !== d) begin errors++;
            $display("FAIL hb_write got %b %h %h exp 1 00aa %h", mem_we, mem_addr, mem_wdata, d); end
        cyc(); #2;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL hb_idle got %b exp 0", mem_we); end
        checks++; if (ram[16'h00AA] !== d) begin errors++; $display("FAIL hb_ram got %h exp %h", ram[16'h00AA], d); end
        cyc();
    endtask

    task automatic test_vblank();
        int px [12] = '{0, 5,   0,   1,   0,   0,   0,   0, 3, 0,   2,   7};
        int py [12] = '{0, 479, 480, 480, 481, 480, 524, 0, 0, 480, 480, 480};
        bit vb = 0, prev = 0;
        int pulses = 0;
        vis = 0; wr_valid = 0;
        for (int i = 0; i < 12; i++) begin
            x = 11'(px[i]); y = 11'(py[i]);
            #2;
            checks++; if (vbs !== prev) begin errors++; $display("FAIL vbs step=%0d got %b exp %b", i, vbs, prev); end
            if (vbs === 1'b1) pulses++;
            prev = !vb && px[i] == 0 && py[i] == IMG_H;
            if (prev) vb = 1; else if (vb && px[i] == 0 && py[i] == 0) vb = 0;
            cyc();
        end
        #2;
        checks++; if (vbs !== prev) begin errors++; $display("FAIL vbs_tail got %b exp %b", vbs, prev); end
        checks++; if (pulses != 2) begin errors++; $display("FAIL vbs_count got %0d exp 2", pulses); end
        x = 700; y = 10;
        cyc();
    endtask

    task automatic test_random();
        wr_t q[$];
        bit  rdy, slot, ewe, hold = 0;
        bit  w1 = 0, w2 = 0, wn;
        for (int c = 0; c < 312; c++) begin
            if (c >= 300) begin
                vis = 0;
                if (!hold) wr_valid = 0;
            end else begin
                vis = $urandom_range(0, 3) != 0;
                x = 11'($urandom_range(40, 620)); y = 11'($urandom_range(0, 500));
                if (!hold) begin wr_valid = 1'($urandom); wr_addr = 16'($urandom); wr_data = 8'($urandom); end
            end
            #2;
            rdy  = q.size() < 4;
            wn   = win(int'(x), int'(y), vis);
            slot = wn && (int'(x) - XO) % 2 == 0;
            ewe  = !slot && q.size() > 0;
            checks++; if (wr_ready !== rdy) begin errors++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, wr_ready, rdy); end
            checks++; if (mem_we !== ewe) begin errors++; $display("FAIL rnd_we c=%0d got %b exp %b", c, mem_we, ewe); end
            if (ewe) begin
                checks++; if (mem_addr !== q[0].a || mem_wdata !== q[0].d) begin errors++;
                    $display("FAIL rnd_data c=%0d got %h:%h exp %h:%h", c, mem_addr, mem_wdata, q[0].a, q[0].d); end
            end
            if (slot) begin
                checks++; if (mem_addr !== 16'({y[8:1], 8'((int'(x) - XO) / 2)})) begin errors++;
                    $display("FAIL rnd_raddr c=%0d got %h exp %h", c, mem_addr, 16'({y[8:1], 8'((int'(x) - XO) / 2)})); end
            end
            if (c >= 2) begin
                checks++; if (pixel_valid !== w2 || (!w2 && pixel !== 8'h0F)) begin errors++;
                    $display("FAIL rnd_pvalid c=%0d got %b/%h exp %b", c, pixel_valid, pixel, w2); end
            end
            w2 = w1; w1 = wn;
            if (ewe) void'(q.pop_front());
            if (wr_valid && rdy) q.push_back('{wr_addr, wr_data});
            hold = wr_valid && !rdy;
            cyc();
        end
        wr_valid = 0;
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d exp 0", q.size()); end
        x = 700; y = 10;
        cyc();
    endtask

    task automatic test_reset_midqueue();
        for (int i = 0; i < 3; i++) ram[16'h2000 + i] = 8'hEE;
        vis = 1; y = 10; x = 100;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1; wr_addr = 16'h2000 + 16'(i); wr_data = 8'(i + 1);
            cyc();
        end
        wr_valid = 0;
        rst_n = 0;
        cyc(); cyc();
        rst_n = 1;
        #2;
        checks++; if (wr_ready !== 1'b1 || mem_we !== 1'b0) begin errors++;
            $display("FAIL mq_release got ready=%b we=%b exp 1/0", wr_ready, mem_we); end
        checks++; if (pixel !== 8'h0F || pixel_valid !== 1'b0) begin errors++;
            $display("FAIL mq_pixel got %h/%b exp 0f/0", pixel, pixel_valid); end
        for (int i = 0; i < 8; i++) begin
            cyc();
            x = 11'(101 + i);
            #2;
            checks++; if (mem_we !== 1'b0 || wr_ready !== 1'b1) begin errors++;
                $display("FAIL mq_drain x=%0d got we=%b ready=%b exp 0/1", x, mem_we, wr_ready); end
        end
        cyc();
        for (int i = 0; i < 3; i++) begin
            checks++; if (ram[16'h2000 + i] !== 8'hEE) begin errors++;
                $display("FAIL mq_ram i=%0d got %h exp ee", i, ram[16'h2000 + i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'(i);
        rst_n = 0; vis = 0; x = 0; y = 0; wr_valid = 0; wr_addr = 0; wr_data = 0;
        test_reset();
        test_scanout();
        test_write_burst();
        test_hblank_write();
        test_vblank();
        test_random();
        test_reset_midqueue();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
